recirculador_lanes: RTL and testbench

//  Multi-lane, parametrised recirculator for the PCIe physical-layer receive path.
//  Per lane: words with valid_in=1 while the link is ACTIVE are buffered in a lane FIFO
//  and then go to the main (demux) path with a valid/ready handshake.
//  All other words go to the probe path, registered.

---
 rtl/recirc_pkg.sv | 23 ++
 rtl/recirc_lane_fifo.sv | 53 +++++
 rtl/recirculador_lanes.sv | 157 +++++++++++++++
 tb/tb_recirculador_lanes.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/recirc_pkg.sv
// Shared definitions for the lane recirculator: link state encodings and a
// ceiling-log2 helper usable in constant expressions.
package recirc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DRAIN  = 2'b10
  } link_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// Single-lane synchronous FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguished without a separate flag.
module recirc_lane_fifo
  import recirc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

  // Head reads as zero when empty so the lane output is clean after reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/recirculador_lanes.sv
// Multi-lane recirculator: words accepted while the link is active are queued
// per lane toward the main path; everything else is registered onto the probe
// path. Optional per-lane probe statistics are built when RECIRC_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | link down, FIFOs empty, all words go to probe
// ST_ACTIVE | link up, valid words are queued per lane
// ST_DRAIN  | link dropped, queued words still drain to main
module recirculador_lanes
  import recirc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_2f,
  input  logic                     reset,
  input  logic [LANES*WIDTH-1:0]   data_in,
  input  logic [LANES-1:0]         valid_in,
  input  logic                     active,
  input  logic [LANES-1:0]         main_ready,
  output logic [LANES*WIDTH-1:0]   main_data,
  output logic [LANES-1:0]         main_valid,
  output logic [LANES*WIDTH-1:0]   probe_data,
  output logic [LANES-1:0]         probe_valid,
  output logic [LANES-1:0]         overflow,
  output logic [1:0]               link_state
`ifdef RECIRC_STATS_EN
  ,
  output logic [LANES*CNT_W-1:0]   probe_cnt
`endif
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_err
    $error("recirculador_lanes: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  link_state_e      state_q;
  link_state_e      state_d;
  logic             accept;
  logic             all_empty;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic [LANES-1:0] reject;
  logic [LANES-1:0] fifo_full;
  logic [LANES-1:0] fifo_empty;
  logic [AW:0]      fifo_cnt [LANES];

  assign link_state = state_q;
  assign main_valid = ~fifo_empty;

  // Both the registered state and the live input must agree before queuing.
  assign accept = (state_q == ST_ACTIVE) && active;

  always_comb begin
    push   = '0;
    pop    = '0;
    reject = '0;
    for (int i = 0; i < LANES; i++) begin
      push[i]   = accept && valid_in[i] && !fifo_full[i];
      reject[i] = accept && valid_in[i] && fifo_full[i];
      pop[i]    = main_valid[i] && main_ready[i];
    end
  end

  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (fifo_cnt[i] != '0) begin
        all_empty = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!active) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (active)         state_d = ST_ACTIVE;
        else if (all_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    recirc_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_2f  (clk_2f),
      .reset   (reset),
      .push    (push[g]),
      .pop     (pop[g]),
      .wr_data (data_in[g*WIDTH +: WIDTH]),
      .head    (main_data[g*WIDTH +: WIDTH]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .count   (fifo_cnt[g])
    );
  end

  // Probe data holds on a push cycle so the last recirculated word stays visible.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      probe_data  <= '0;
      probe_valid <= '0;
      overflow    <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!push[i]) begin
          probe_data[i*WIDTH +: WIDTH] <= data_in[i*WIDTH +: WIDTH];
          probe_valid[i]               <= valid_in[i];
        end else begin
          probe_valid[i] <= 1'b0;
        end
        if (reject[i]) begin
          overflow[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RECIRC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      probe_cnt <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!push[i] && valid_in[i] && (probe_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          probe_cnt[i*CNT_W +: CNT_W] <= probe_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_recirculador_lanes.sv
// Scoreboard bench for recirculador_lanes: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_recirculador_lanes;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int BW    = LANES * WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [1:0] L_IDLE   = 2'b00;
  localparam logic [1:0] L_ACTIVE = 2'b01;
  localparam logic [1:0] L_DRAIN  = 2'b10;

  logic             clk_2f = 1'b0;
  logic             reset = 1'b0;
  logic             active = 1'b0;
  logic [BW-1:0]    data_in = '0;
  logic [LANES-1:0] valid_in = '0;
  logic [LANES-1:0] main_ready = '0;
  logic [BW-1:0]    main_data;
  logic [LANES-1:0] main_valid;
  logic [BW-1:0]    probe_data;
  logic [LANES-1:0] probe_valid;
  logic [LANES-1:0] overflow;
  logic [1:0]       link_state;
`ifdef RECIRC_STATS_EN
  logic [LANES*CNT_W-1:0] probe_cnt;
`endif

  recirculador_lanes #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .active      (active),
    .main_ready  (main_ready),
    .main_data   (main_data),
    .main_valid  (main_valid),
    .probe_data  (probe_data),
    .probe_valid (probe_valid),
    .overflow    (overflow),
    .link_state  (link_state)
`ifdef RECIRC_STATS_EN
    ,
    .probe_cnt   (probe_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: words expected on the main path, in order, per lane.
  logic [WIDTH-1:0] exq [LANES][$];

  // Reference model state as seen after the most recent clock edge.
  logic [1:0]       e_state = L_IDLE;
  int               e_cnt [LANES];
  logic [BW-1:0]    e_pd = '0;
  logic [LANES-1:0] e_pv = '0;
  logic [LANES-1:0] e_ov = '0;
  int               e_pc [LANES];
  bit               e_rst = 1'b0;
  bit               checking = 1'b0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] lane_word(input int lane, input logic [WIDTH-1:0] w);
    logic [BW-1:0] v;
    v = '0;
    v[lane*WIDTH +: WIDTH] = w;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_data();
    logic [BW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom();
    return v;
  endfunction

  // Apply one cycle of inputs, predict the post-edge state, then advance.
  task automatic step(input logic rst_v, input logic act_v, input logic [LANES-1:0] val_v,
                      input logic [BW-1:0] dat_v, input logic [LANES-1:0] rdy_v);
    logic [1:0]       n_state;
    int               n_cnt [LANES];
    logic [BW-1:0]    n_pd;
    logic [LANES-1:0] n_pv;
    logic [LANES-1:0] n_ov;
    int               n_pc [LANES];
    bit               acc;
    bit               drained;
    bit               pu;
    bit               po;
    reset      = rst_v;
    active     = act_v;
    valid_in   = val_v;
    data_in    = dat_v;
    main_ready = rdy_v;
    if (!rst_v) begin
      n_state = L_IDLE;
      n_pd    = '0;
      n_pv    = '0;
      n_ov    = '0;
      for (int i = 0; i < LANES; i++) begin
        n_cnt[i] = 0;
        n_pc[i]  = 0;
      end
    end else begin
      acc     = (e_state == L_ACTIVE) && act_v;
      drained = 1'b1;
      n_pd    = e_pd;
      n_pv    = e_pv;
      n_ov    = e_ov;
      for (int i = 0; i < LANES; i++) begin
        if (e_cnt[i] != 0) drained = 1'b0;
        pu = acc && val_v[i] && (e_cnt[i] < DEPTH);
        po = (e_cnt[i] > 0) && rdy_v[i];
        n_cnt[i] = e_cnt[i] + (pu ? 1 : 0) - (po ? 1 : 0);
        n_pc[i]  = e_pc[i];
        if (pu) begin
          exq[i].push_back(dat_v[i*WIDTH +: WIDTH]);
          n_pv[i] = 1'b0;
        end else begin
          n_pd[i*WIDTH +: WIDTH] = dat_v[i*WIDTH +: WIDTH];
          n_pv[i] = val_v[i];
          if (val_v[i] && e_pc[i] < CMAX) n_pc[i] = e_pc[i] + 1;
        end
        if (acc && val_v[i] && e_cnt[i] >= DEPTH) n_ov[i] = 1'b1;
      end
      case (e_state)
        L_IDLE:   n_state = act_v ? L_ACTIVE : L_IDLE;
        L_ACTIVE: n_state = act_v ? L_ACTIVE : L_DRAIN;
        default:  n_state = act_v ? L_ACTIVE : (drained ? L_IDLE : L_DRAIN);
      endcase
    end
    @(posedge clk_2f);
    e_state = n_state;
    e_pd    = n_pd;
    e_pv    = n_pv;
    e_ov    = n_ov;
    e_rst   = !rst_v;
    for (int i = 0; i < LANES; i++) begin
      e_cnt[i] = n_cnt[i];
      e_pc[i]  = n_pc[i];
      if (!rst_v) exq[i].delete();
    end
    if (!rst_v) checking = 1'b1;
    #1;
  endtask

  // Monitor: compares registered outputs and consumes main-path words on handshake.
  always @(negedge clk_2f) begin
    logic [LANES-1:0] exp_mv;
    if (checking) begin
      for (int i = 0; i < LANES; i++) exp_mv[i] = (e_cnt[i] > 0);
      chk("link_state", BW'(link_state), BW'(e_state));
      chk("main_valid", BW'(main_valid), BW'(exp_mv));
      chk("probe_data", probe_data, e_pd);
      chk("probe_valid", BW'(probe_valid), BW'(e_pv));
      chk("overflow", BW'(overflow), BW'(e_ov));
      if (e_rst) chk("main_data_reset", main_data, '0);
`ifdef RECIRC_STATS_EN
      for (int i = 0; i < LANES; i++)
        chk("probe_cnt", BW'(probe_cnt[i*CNT_W +: CNT_W]), BW'(e_pc[i]));
`endif
      for (int i = 0; i < LANES; i++) begin
        if (main_valid[i]) begin
          if (exq[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL main_data lane %0d: got %h expected no word at %0t",
                     i, main_data[i*WIDTH +: WIDTH], $time);
          end else begin
            chk("main_data", BW'(main_data[i*WIDTH +: WIDTH]), BW'(exq[i][0]));
            if (main_ready[i]) void'(exq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic             act_r;
    logic [LANES-1:0] val_r;
    logic [LANES-1:0] rdy_r;
    for (int i = 0; i < LANES; i++) begin
      e_cnt[i] = 0;
      e_pc[i]  = 0;
    end

    // Reset with busy inputs.
    repeat (2) step(1'b0, 1'b0, 4'hF, {LANES{32'hA5A5A5A5}}, 4'hF);

    // Lane 0 words pass straight through the FIFO to main.
    step(1'b1, 1'b1, 4'h0, '0, 4'hF);
    for (int w = 1; w <= 4; w++) step(1'b1, 1'b1, 4'b0001, lane_word(0, WIDTH'(w)), 4'hF);
    repeat (3) step(1'b1, 1'b1, 4'h0, '0, 4'hF);

    // Lane 1 overflows: fifth word goes to probe, then the four drain in order.
    for (int w = 1; w <= 5; w++) step(1'b1, 1'b1, 4'b0010, lane_word(1, WIDTH'(32'h10 + w)), 4'h0);
    repeat (6) step(1'b1, 1'b1, 4'h0, '0, 4'hF);

    // Link drop with words queued: DRAIN until empty, late word goes to probe.
    for (int w = 1; w <= 3; w++) step(1'b1, 1'b1, 4'b0100, lane_word(2, WIDTH'(32'h20 + w)), 4'h0);
    step(1'b1, 1'b0, 4'b0100, lane_word(2, 32'h0000DEAD), 4'h0);
    repeat (2) step(1'b1, 1'b0, 4'h0, '0, 4'h0);
    repeat (6) step(1'b1, 1'b0, 4'h0, '0, 4'hF);

    // Non-valid words while active, then valid idle-path words (counter saturation).
    repeat (4) step(1'b1, 1'b1, 4'h0, rand_data(), 4'hF);
    repeat (5) step(1'b1, 1'b0, 4'hF, rand_data(), 4'hF);

    // Reset while FIFOs are half full.
    step(1'b1, 1'b1, 4'h0, '0, 4'h0);
    repeat (2) step(1'b1, 1'b1, 4'hF, rand_data(), 4'h0);
    step(1'b0, 1'b1, 4'hF, rand_data(), 4'h0);
    repeat (2) step(1'b1, 1'b0, 4'h0, '0, 4'h0);

    // Randomized traffic.
    act_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) act_r = ~act_r;
      for (int i = 0; i < LANES; i++) begin
        val_r[i] = ($urandom_range(0, 9) < 7);
        rdy_r[i] = ($urandom_range(0, 9) < 5);
      end
      step(($urandom_range(0, 199) != 0), act_r, val_r, rand_data(), rdy_r);
    end

    // Final drain: every scoreboard word must have been seen.
    repeat (2 * DEPTH + 4) step(1'b1, 1'b0, 4'h0, '0, 4'hF);
    @(negedge clk_2f);
    for (int i = 0; i < LANES; i++) chk("scoreboard_empty", BW'(exq[i].size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
